// File: rtl/rs_issue_station.sv
// Age-ordered reservation station. Entries form a collapsing queue (index 0 is
// the oldest). Operands wake up from the common data bus, and the oldest
// entry with both operands ready and a willing function unit issues.
module rs_issue_station #(
  parameter int RS_DEPTH      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_ENTRY     = 4,
  parameter int PAYLOAD_WIDTH = 70,
  parameter int FU_TYPES      = 4,
  localparam int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY),
  localparam int FUNCTION_W     = $clog2(FU_TYPES),
  localparam int CNT_W          = $clog2(RS_DEPTH + 1)
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [FUNCTION_W-1:0]     disp_function,
  input  logic [PAYLOAD_WIDTH-1:0]  disp_payload,
  input  logic [ROB_ENTRY_LOG2-1:0] disp_rob_entry,
  input  logic                      disp_rs1_ready,
  input  logic                      disp_rs2_ready,
  input  logic [DATA_WIDTH-1:0]     disp_rs1_data,
  input  logic [DATA_WIDTH-1:0]     disp_rs2_data,
  input  logic [ROB_ENTRY_LOG2-1:0] disp_rs1_alias,
  input  logic [ROB_ENTRY_LOG2-1:0] disp_rs2_alias,
  input  logic                      cdb_valid,
  input  logic [ROB_ENTRY_LOG2-1:0] cdb_alias,
  input  logic [DATA_WIDTH-1:0]     cdb_data,
  input  logic [FU_TYPES-1:0]       fu_wok,
  output logic                      isr_valid,
  output logic [FUNCTION_W-1:0]     isr_function,
  output logic [PAYLOAD_WIDTH-1:0]  isr_payload,
  output logic [ROB_ENTRY_LOG2-1:0] isr_rob_entry,
  output logic [DATA_WIDTH-1:0]     isr_rs1_data,
  output logic [DATA_WIDTH-1:0]     isr_rs2_data,
  output logic [CNT_W-1:0]          rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  // Entry state: valid and count are control (reset); the rest is data.
  logic                      valid_q [RS_DEPTH];
  logic                      valid_d [RS_DEPTH];
  logic [FUNCTION_W-1:0]     func_q  [RS_DEPTH];
  logic [FUNCTION_W-1:0]     func_d  [RS_DEPTH];
  logic [PAYLOAD_WIDTH-1:0]  pay_q   [RS_DEPTH];
  logic [PAYLOAD_WIDTH-1:0]  pay_d   [RS_DEPTH];
  logic [ROB_ENTRY_LOG2-1:0] rob_q   [RS_DEPTH];
  logic [ROB_ENTRY_LOG2-1:0] rob_d   [RS_DEPTH];
  logic                      r1_q    [RS_DEPTH];
  logic                      r1_d    [RS_DEPTH];
  logic                      r2_q    [RS_DEPTH];
  logic                      r2_d    [RS_DEPTH];
  logic [DATA_WIDTH-1:0]     d1_q    [RS_DEPTH];
  logic [DATA_WIDTH-1:0]     d1_d    [RS_DEPTH];
  logic [DATA_WIDTH-1:0]     d2_q    [RS_DEPTH];
  logic [DATA_WIDTH-1:0]     d2_d    [RS_DEPTH];
  logic [ROB_ENTRY_LOG2-1:0] a1_q    [RS_DEPTH];
  logic [ROB_ENTRY_LOG2-1:0] a1_d    [RS_DEPTH];
  logic [ROB_ENTRY_LOG2-1:0] a2_q    [RS_DEPTH];
  logic [ROB_ENTRY_LOG2-1:0] a2_d    [RS_DEPTH];
  logic [CNT_W-1:0]          count_q;
  logic [CNT_W-1:0]          count_d;

  // Post-wakeup view of every entry, with one extra empty slot on top so the
  // collapse can always read index i+1.
  logic                      w_valid [RS_DEPTH+1];
  logic [FUNCTION_W-1:0]     w_func  [RS_DEPTH+1];
  logic [PAYLOAD_WIDTH-1:0]  w_pay   [RS_DEPTH+1];
  logic [ROB_ENTRY_LOG2-1:0] w_rob   [RS_DEPTH+1];
  logic                      w_r1    [RS_DEPTH+1];
  logic                      w_r2    [RS_DEPTH+1];
  logic [DATA_WIDTH-1:0]     w_d1    [RS_DEPTH+1];
  logic [DATA_WIDTH-1:0]     w_d2    [RS_DEPTH+1];
  logic [ROB_ENTRY_LOG2-1:0] w_a1    [RS_DEPTH+1];
  logic [ROB_ENTRY_LOG2-1:0] w_a2    [RS_DEPTH+1];

  logic             issue;
  logic [IDX_W-1:0] sel_idx;
  logic             accept;
  logic [CNT_W-1:0] wr_idx;
  logic             new_r1;
  logic             new_r2;
  logic [DATA_WIDTH-1:0] new_d1;
  logic [DATA_WIDTH-1:0] new_d2;

  // Pick the oldest entry whose operands are ready in registered state and
  // whose function unit accepts this cycle.
  always_comb begin
    issue   = 1'b0;
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && r1_q[i] && r2_q[i] && fu_wok[func_q[i]]) begin
        issue   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Issue outputs show the selected entry and are forced to zero when idle.
  always_comb begin
    isr_valid     = issue;
    isr_function  = '0;
    isr_payload   = '0;
    isr_rob_entry = '0;
    isr_rs1_data  = '0;
    isr_rs2_data  = '0;
    if (issue) begin
      isr_function  = func_q[sel_idx];
      isr_payload   = pay_q[sel_idx];
      isr_rob_entry = rob_q[sel_idx];
      isr_rs1_data  = d1_q[sel_idx];
      isr_rs2_data  = d2_q[sel_idx];
    end
  end

  // Dispatch handshake and the incoming entry, with same-cycle CDB bypass.
  always_comb begin
    rs_count   = count_q;
    disp_ready = (count_q < CNT_W'(RS_DEPTH));
    accept     = disp_valid & disp_ready & ~flush;
    wr_idx     = count_q - CNT_W'(issue);
    new_r1     = disp_rs1_ready | (cdb_valid & (disp_rs1_alias == cdb_alias));
    new_r2     = disp_rs2_ready | (cdb_valid & (disp_rs2_alias == cdb_alias));
    new_d1     = disp_rs1_ready ? disp_rs1_data : cdb_data;
    new_d2     = disp_rs2_ready ? disp_rs2_data : cdb_data;
  end

  // Wakeup, collapse over the issued slot, dispatch write and flush.
  always_comb begin
    int src;
    src = 0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_valid[i] = valid_q[i];
      w_func[i]  = func_q[i];
      w_pay[i]   = pay_q[i];
      w_rob[i]   = rob_q[i];
      w_a1[i]    = a1_q[i];
      w_a2[i]    = a2_q[i];
      w_r1[i]    = r1_q[i];
      w_d1[i]    = d1_q[i];
      w_r2[i]    = r2_q[i];
      w_d2[i]    = d2_q[i];
      if (cdb_valid && !r1_q[i] && (a1_q[i] == cdb_alias)) begin
        w_r1[i] = 1'b1;
        w_d1[i] = cdb_data;
      end
      if (cdb_valid && !r2_q[i] && (a2_q[i] == cdb_alias)) begin
        w_r2[i] = 1'b1;
        w_d2[i] = cdb_data;
      end
    end
    w_valid[RS_DEPTH] = 1'b0;
    w_func[RS_DEPTH]  = '0;
    w_pay[RS_DEPTH]   = '0;
    w_rob[RS_DEPTH]   = '0;
    w_a1[RS_DEPTH]    = '0;
    w_a2[RS_DEPTH]    = '0;
    w_r1[RS_DEPTH]    = 1'b0;
    w_d1[RS_DEPTH]    = '0;
    w_r2[RS_DEPTH]    = 1'b0;
    w_d2[RS_DEPTH]    = '0;

    for (int i = 0; i < RS_DEPTH; i++) begin
      src = (issue && (i >= int'(sel_idx))) ? i + 1 : i;
      valid_d[i] = w_valid[src];
      func_d[i]  = w_func[src];
      pay_d[i]   = w_pay[src];
      rob_d[i]   = w_rob[src];
      a1_d[i]    = w_a1[src];
      a2_d[i]    = w_a2[src];
      r1_d[i]    = w_r1[src];
      d1_d[i]    = w_d1[src];
      r2_d[i]    = w_r2[src];
      d2_d[i]    = w_d2[src];
      if (accept && (CNT_W'(i) == wr_idx)) begin
        valid_d[i] = 1'b1;
        func_d[i]  = disp_function;
        pay_d[i]   = disp_payload;
        rob_d[i]   = disp_rob_entry;
        a1_d[i]    = disp_rs1_alias;
        a2_d[i]    = disp_rs2_alias;
        r1_d[i]    = new_r1;
        d1_d[i]    = new_d1;
        r2_d[i]    = new_r2;
        d2_d[i]    = new_d2;
      end
      if (flush) valid_d[i] = 1'b0;
    end

    count_d = flush ? '0 : count_q + CNT_W'(accept) - CNT_W'(issue);
  end

  // Control state: occupancy and per-entry valid bits.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) valid_q[i] <= valid_d[i];
    end
  end

  // Entry contents; only meaningful while the matching valid bit is set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      func_q[i] <= func_d[i];
      pay_q[i]  <= pay_d[i];
      rob_q[i]  <= rob_d[i];
      a1_q[i]   <= a1_d[i];
      a2_q[i]   <= a2_d[i];
      r1_q[i]   <= r1_d[i];
      d1_q[i]   <= d1_d[i];
      r2_q[i]   <= r2_d[i];
      d2_q[i]   <= d2_d[i];
    end
  end

endmodule

// File: tb/tb_rs_issue_station.sv
// Bench for rs_issue_station: directed scenarios then random traffic, checked
// each cycle against a queue-based model of the station.
module tb_rs_issue_station;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [1:0]  disp_function;
  logic [69:0] disp_payload;
  logic [1:0]  disp_rob_entry;
  logic        disp_rs1_ready, disp_rs2_ready;
  logic [31:0] disp_rs1_data, disp_rs2_data;
  logic [1:0]  disp_rs1_alias, disp_rs2_alias;
  logic        cdb_valid;
  logic [1:0]  cdb_alias;
  logic [31:0] cdb_data;
  logic [3:0]  fu_wok;
  logic        isr_valid;
  logic [1:0]  isr_function;
  logic [69:0] isr_payload;
  logic [1:0]  isr_rob_entry;
  logic [31:0] isr_rs1_data, isr_rs2_data;
  logic [2:0]  rs_count;

  rs_issue_station dut (
    .CLK(CLK), .RSTN(RSTN), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_function(disp_function), .disp_payload(disp_payload),
    .disp_rob_entry(disp_rob_entry),
    .disp_rs1_ready(disp_rs1_ready), .disp_rs2_ready(disp_rs2_ready),
    .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
    .disp_rs1_alias(disp_rs1_alias), .disp_rs2_alias(disp_rs2_alias),
    .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_data(cdb_data),
    .fu_wok(fu_wok),
    .isr_valid(isr_valid), .isr_function(isr_function),
    .isr_payload(isr_payload), .isr_rob_entry(isr_rob_entry),
    .isr_rs1_data(isr_rs1_data), .isr_rs2_data(isr_rs2_data),
    .rs_count(rs_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  fn;
    logic [69:0] pay;
    logic [1:0]  rob;
    bit          r1, r2;
    logic [31:0] d1, d2;
    logic [1:0]  a1, a2;
  } ent_t;

  typedef struct {
    bit          v;
    logic [1:0]  fn;
    logic [69:0] pay;
    logic [1:0]  rob;
    logic [31:0] d1, d2;
    int          cnt;
    bit          rdy;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   iss_idx;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: once per cycle, pop the expectation and compare every output.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("isr_valid",     128'(isr_valid),     128'(e.v));
        chk("isr_function",  128'(isr_function),  128'(e.fn));
        chk("isr_payload",   128'(isr_payload),   128'(e.pay));
        chk("isr_rob_entry", 128'(isr_rob_entry), 128'(e.rob));
        chk("isr_rs1_data",  128'(isr_rs1_data),  128'(e.d1));
        chk("isr_rs2_data",  128'(isr_rs2_data),  128'(e.d2));
        chk("rs_count",      128'(rs_count),      128'(e.cnt));
        chk("disp_ready",    128'(disp_ready),    128'(e.rdy));
      end
    end
  end

  // One clock: predict outputs from the model, let the edge pass, then
  // advance the model with the inputs that were applied.
  task automatic tick();
    exp_t e;
    ent_t n;
    bit   acc;
    #1;
    if (!RSTN) mq.delete();
    iss_idx = -1;
    foreach (mq[i])
      if (iss_idx < 0 && mq[i].r1 && mq[i].r2 && fu_wok[mq[i].fn]) iss_idx = i;
    e = '{v: 1'b0, fn: '0, pay: '0, rob: '0, d1: '0, d2: '0, cnt: mq.size(), rdy: (mq.size() < DEPTH)};
    if (iss_idx >= 0) begin
      e.v   = 1'b1;
      e.fn  = mq[iss_idx].fn;
      e.pay = mq[iss_idx].pay;
      e.rob = mq[iss_idx].rob;
      e.d1  = mq[iss_idx].d1;
      e.d2  = mq[iss_idx].d2;
    end
    exp_q.push_back(e);
    acc = disp_valid && (mq.size() < DEPTH) && !flush;
    @(posedge CLK);
    if (RSTN) begin
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].r1 && mq[i].a1 == cdb_alias) begin mq[i].r1 = 1; mq[i].d1 = cdb_data; end
          if (!mq[i].r2 && mq[i].a2 == cdb_alias) begin mq[i].r2 = 1; mq[i].d2 = cdb_data; end
        end
      end
      if (iss_idx >= 0) mq.delete(iss_idx);
      if (acc) begin
        n.fn = disp_function; n.pay = disp_payload; n.rob = disp_rob_entry;
        n.a1 = disp_rs1_alias; n.a2 = disp_rs2_alias;
        n.r1 = disp_rs1_ready; n.d1 = disp_rs1_data;
        n.r2 = disp_rs2_ready; n.d2 = disp_rs2_data;
        if (!n.r1 && cdb_valid && n.a1 == cdb_alias) begin n.r1 = 1; n.d1 = cdb_data; end
        if (!n.r2 && cdb_valid && n.a2 == cdb_alias) begin n.r2 = 1; n.d2 = cdb_data; end
        mq.push_back(n);
      end
      if (flush) mq.delete();
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    disp_valid = 0; flush = 0; cdb_valid = 0;
  endtask

  task automatic disp(input logic [1:0] fn, input bit r1, input logic [31:0] d1, input logic [1:0] a1,
                      input bit r2, input logic [31:0] d2, input logic [1:0] a2, input logic [1:0] rob);
    logic [95:0] p;
    p = {$urandom, $urandom, $urandom};
    disp_valid = 1; disp_function = fn; disp_payload = p[69:0]; disp_rob_entry = rob;
    disp_rs1_ready = r1; disp_rs1_data = d1; disp_rs1_alias = a1;
    disp_rs2_ready = r2; disp_rs2_data = d2; disp_rs2_alias = a2;
  endtask

  initial begin
    logic [31:0] rv;
    RSTN = 0; fu_wok = 4'b1111; cdb_alias = 0; cdb_data = 0;
    disp(0, 1, 0, 0, 1, 0, 0, 0);
    idle();
    @(negedge CLK);
    tick(); tick();
    RSTN = 1;

    // Basic ADD issue
    disp(0, 1, 32'd5, 0, 1, 32'd7, 0, 1); tick();
    idle(); tick(); tick();

    // Out-of-order issue, then wakeup of the older entry
    disp(1, 0, 0, 2, 1, 32'h11, 0, 2); tick();
    disp(0, 1, 32'h22, 0, 1, 32'h33, 0, 3); tick();
    idle(); tick();
    cdb_valid = 1; cdb_alias = 2; cdb_data = 32'h99; tick();
    idle(); tick(); tick();

    // Dispatch-time bypass of rs2
    disp(2, 1, 32'h44, 0, 0, 0, 3, 0);
    cdb_valid = 1; cdb_alias = 3; cdb_data = 32'h55; tick();
    idle(); tick(); tick();

    // Fill while blocked, then release only the ALU in slot 2
    fu_wok = 4'b0000;
    disp(1, 1, 32'h1, 0, 1, 32'h2, 0, 0); tick();
    disp(2, 1, 32'h3, 0, 1, 32'h4, 0, 1); tick();
    disp(0, 1, 32'h5, 0, 1, 32'h6, 0, 2); tick();
    disp(3, 1, 32'h7, 0, 1, 32'h8, 0, 3); tick();
    disp(0, 1, 32'h9, 0, 1, 32'ha, 0, 0); tick();
    idle(); fu_wok = 4'b0001; tick(); tick();
    fu_wok = 4'b1111; tick(); tick(); tick(); tick();

    // Flush with a simultaneous dispatch
    fu_wok = 4'b0000;
    disp(0, 1, 1, 0, 1, 2, 0, 0); tick(); tick(); tick();
    flush = 1; tick();
    idle(); fu_wok = 4'b1111; tick(); tick(); tick();

    // Asynchronous reset with pending entries
    fu_wok = 4'b0000;
    disp(1, 1, 3, 0, 1, 4, 0, 1); tick(); tick();
    idle(); RSTN = 0; tick();
    RSTN = 1; fu_wok = 4'b1111; tick(); tick(); tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rv = $urandom;
      disp(rv[1:0], rv[4:2] != 0, $urandom, rv[6:5], rv[9:7] != 0, $urandom, rv[11:10], rv[13:12]);
      disp_valid = rv[14];
      cdb_valid  = rv[15]; cdb_alias = rv[17:16]; cdb_data = $urandom;
      fu_wok     = rv[21:18];
      flush      = (rv[27:22] == 0);
      RSTN       = (rv[31:28] != 0) || c[3];
      tick();
    end
    RSTN = 1; idle(); fu_wok = 4'b1111;
    for (int c = 0; c < 8; c++) tick();

    @(negedge CLK); #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
